// File: rtl/ysyx_23060332_pkg.sv
// Shared definitions for the NPC core: bus widths, the reset PC and the
// instruction-fetch FSM state encoding.
package ysyx_23060332_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;

  localparam logic [InstAddrW-1:0] InstAddrBus = '0;
  localparam logic [InstW-1:0]     InstBus     = '0;
  localparam logic [31:0]          ZeroWord    = 32'h0000_0000;

  localparam logic [31:0] ysyx_23060332_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    IfuIdle = 2'd0,
    IfuReq  = 2'd1,
    IfuWait = 2'd2,
    IfuHold = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter register with its next-PC mux.
//   clk, rst     : core clock, asynchronous active-high reset
//   inc_en_i     : advance PC by 4 (wraps)
//   jump_en_i    : load redirect target (has priority over inc_en_i)
//   jump_addr_i  : redirect target; low two bits are cleared
//   pc_o         : current PC
module ysyx_23060332_pc_reg
  import ysyx_23060332_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ysyx_23060332_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (jump_en_i) begin
      pc_d = jump_addr_i & ~ADDR_W'(3);
    end else if (inc_en_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding imem read at a
// time and holds the fetched instruction for decode under valid/ready.
//   imem_req_*   : request channel to instruction memory (addr = PC)
//   imem_rsp_*   : response channel, no backpressure
//   inst_*_o     : instruction and its PC presented to decode
//   idu_ready_i  : decode consumes the held instruction
//   jump_*_i     : single-cycle PC redirect; squashes stale fetches
// All outputs come straight from registers/state.
module ysyx_23060332_ifu
  import ysyx_23060332_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrW,
  parameter int unsigned       INST_W   = InstW,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ysyx_23060332_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid_o,
  input  logic              idu_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i
);

  ifu_state_e        state_d, state_q;
  logic              drop_d, drop_q;
  logic [INST_W-1:0] inst_d, inst_q;
  logic [ADDR_W-1:0] inst_addr_d, inst_addr_q;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;

  ysyx_23060332_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .inc_en_i   (pc_inc),
    .jump_en_i  (jump_en_i),
    .jump_addr_i(jump_addr_i),
    .pc_o       (pc)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    pc_inc      = 1'b0;
    unique case (state_q)
      IfuIdle: state_d = IfuReq;
      IfuReq: begin
        if (imem_req_ready) begin
          state_d = IfuWait;
          // Request already accepted at the old PC: its data must be thrown away.
          if (jump_en_i) drop_d = 1'b1;
        end
      end
      IfuWait: begin
        if (imem_rsp_valid) begin
          if (drop_q || jump_en_i) begin
            state_d = IfuReq;
            drop_d  = 1'b0;
          end else begin
            state_d     = IfuHold;
            inst_d      = imem_rsp_data;
            inst_addr_d = pc;
          end
        end else if (jump_en_i) begin
          drop_d = 1'b1;
        end
      end
      IfuHold: begin
        // A redirect moves on regardless; the pc_reg gives jump priority over +4.
        if (jump_en_i) begin
          state_d = IfuReq;
        end else if (idu_ready_i) begin
          state_d = IfuReq;
          pc_inc  = 1'b1;
        end
      end
      default: state_d = IfuIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IfuIdle;
      drop_q      <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
    end
  end

  assign imem_req_valid = (state_q == IfuReq);
  assign imem_req_addr  = pc;
  assign inst_valid_o   = (state_q == IfuHold);
  assign inst_o         = inst_q;
  assign inst_addr_o    = inst_addr_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Cycle-accurate vector table for the fetch unit plus a scoreboard of
// instructions expected to be consumed by decode.
module tb_ysyx_23060332_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid_o;
  logic        idu_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_23060332_ifu dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid_o  (inst_valid_o),
    .idu_ready_i   (idu_ready_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i)
  );

  typedef struct {
    logic        rr;    // imem_req_ready driven this cycle
    logic        rv;    // imem_rsp_valid
    logic [31:0] rd;    // imem_rsp_data
    logic        ir;    // idu_ready_i
    logic        je;    // jump_en_i
    logic [31:0] ja;    // jump_addr_i
    logic        push;  // this response will reach decode
    logic        erv;   // expected outputs at start of the cycle
    logic [31:0] era;
    logic        eiv;
    logic [31:0] ei;
    logic [31:0] eia;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];   // {inst, addr} expected at decode handshake

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rr, input logic rv, input logic [31:0] rd, input logic ir,
                     input logic je, input logic [31:0] ja, input logic push,
                     input logic erv, input logic [31:0] era, input logic eiv,
                     input logic [31:0] ei, input logic [31:0] eia);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.je = je; v.ja = ja; v.push = push;
    v.erv = erv; v.era = era; v.eiv = eiv; v.ei = ei; v.eia = eia;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    idu_ready_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      vec_t v;
      v = tbl[i];
      chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, v.erv});
      chk($sformatf("row%0d req_addr", i), imem_req_addr, v.era);
      chk($sformatf("row%0d inst_valid", i), {31'b0, inst_valid_o}, {31'b0, v.eiv});
      chk($sformatf("row%0d inst", i), inst_o, v.ei);
      chk($sformatf("row%0d inst_addr", i), inst_addr_o, v.eia);
      imem_req_ready = v.rr; imem_rsp_valid = v.rv; imem_rsp_data = v.rd;
      idu_ready_i = v.ir; jump_en_i = v.je; jump_addr_i = v.ja;
      if (v.push) sb.push_back({v.rd, v.era});
      step();
    end
  endtask

  // Decode-side scoreboard: sampled mid-cycle, ahead of the consuming edge.
  always @(negedge clk) begin
    if (!rst && inst_valid_o && idu_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got inst %h addr %h expected no instruction",
                 inst_o, inst_addr_o);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_inst", inst_o, e[63:32]);
        chk("sb_addr", inst_addr_o, e[31:0]);
      end
    end
  end

  localparam logic [31:0] Rst = 32'h8000_0000;
  localparam logic [31:0] D0  = 32'h0010_0093;

  int split;

  initial begin
    // Phase A: fetch, stall, redirects, wrap.
    add(1, 0, 0, 0, 0, 0, 0,  0, Rst, 0, 0, 0);                         // IDLE
    add(1, 0, 0, 0, 0, 0, 0,  1, Rst, 0, 0, 0);                         // REQ
    add(0, 1, D0, 0, 0, 0, 1, 0, Rst, 0, 0, 0);                         // WAIT
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 0, 0, 0, Rst, 1, D0, Rst);
    add(0, 0, 0, 1, 0, 0, 0,  0, Rst, 1, D0, Rst);                      // consume
    add(1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0004, 0, D0, Rst);            // REQ +4
    add(0, 0, 0, 0, 1, 32'h8000_0103, 0, 0, 32'h8000_0004, 0, D0, Rst); // jump in WAIT
    add(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h8000_0100, 0, D0, Rst); // dropped
    add(0, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0100, 0, D0, Rst);            // REQ stall
    add(1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0100, 0, D0, Rst);
    add(0, 1, 32'h0000_0013, 0, 0, 0, 1, 0, 32'h8000_0100, 0, D0, Rst);
    add(0, 0, 0, 1, 0, 0, 0,  0, 32'h8000_0100, 1, 32'h13, 32'h8000_0100);
    add(1, 0, 0, 0, 1, 32'h8000_0200, 0, 1, 32'h8000_0104, 0, 32'h13, 32'h8000_0100);
    add(0, 1, 32'h0000_BAD0, 0, 0, 0, 0, 0, 32'h8000_0200, 0, 32'h13, 32'h8000_0100);
    add(1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0200, 0, 32'h13, 32'h8000_0100);
    add(0, 1, 32'h1111_1111, 0, 0, 0, 1, 0, 32'h8000_0200, 0, 32'h13, 32'h8000_0100);
    add(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h8000_0200, 1, 32'h1111_1111, 32'h8000_0200);
    add(1, 0, 0, 0, 0, 0, 0,  1, 32'hFFFF_FFFC, 0, 32'h1111_1111, 32'h8000_0200);
    add(0, 1, 32'h2222_2222, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 32'h1111_1111, 32'h8000_0200);
    add(0, 0, 0, 1, 0, 0, 0,  0, 32'hFFFF_FFFC, 1, 32'h2222_2222, 32'hFFFF_FFFC);
    add(1, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0000, 0, 32'h2222_2222, 32'hFFFF_FFFC); // wrapped
    add(0, 1, 32'h3333_3333, 0, 1, 32'h8000_0010, 0, 0, 32'h0, 0, 32'h2222_2222, 32'hFFFF_FFFC);
    add(1, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0010, 0, 32'h2222_2222, 32'hFFFF_FFFC);
    add(0, 1, 32'h4444_4444, 0, 0, 0, 1, 0, 32'h8000_0010, 0, 32'h2222_2222, 32'hFFFF_FFFC);
    add(0, 0, 0, 0, 0, 0, 0,  0, 32'h8000_0010, 1, 32'h4444_4444, 32'h8000_0010);
    split = tbl.size();
    // Phase B: restart after a reset taken in WAIT.
    add(1, 0, 0, 0, 0, 0, 0,  0, Rst, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,  1, Rst, 0, 0, 0);
    add(0, 1, 32'h5555_5555, 0, 0, 0, 1, 0, Rst, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0,  0, Rst, 1, 32'h5555_5555, Rst);
    add(0, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0004, 0, 32'h5555_5555, Rst);

    rst = 1'b1;
    drive_idle();
    step();
    step();
    rst = 1'b0;
    run_rows(0, split);

    // Consume the held instruction, issue one more fetch, reset while in WAIT.
    drive_idle();
    idu_ready_i = 1'b1;
    step();
    drive_idle();
    imem_req_ready = 1'b1;
    step();
    drive_idle();
    chk("pre_rst req_addr", imem_req_addr, 32'h8000_0014);
    rst = 1'b1;
    #1;
    chk("rst req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst inst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("rst inst", inst_o, 32'h0);
    chk("rst inst_addr", inst_addr_o, 32'h0);
    chk("rst req_addr", imem_req_addr, Rst);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h6666_6666;
    step();
    drive_idle();
    chk("late_rsp inst_valid", {31'b0, inst_valid_o}, 32'h0);
    chk("late_rsp inst", inst_o, 32'h0);
    rst = 1'b0;
    run_rows(split, tbl.size());

    drive_idle();
    step();
    chk("sb_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
